// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// ---------------
// CPU-side initiator for a single-port synchronous data memory. It accepts one
// load/store request at a time, latches it into MAR/MDR, drives the memory
// pins, captures read data into MDR after RD_LAT edges and returns a
// one-cycle response. Every output is decoded from registered state, so there
// is no combinational path from req to any mem_* pin.
//
// Parameters:
//   DEPTH   number of 32-bit words in the memory (used only for range checking)
//   RD_LAT  edges from address presentation until mem_q is valid (1..4)
//
// Optional feature (macro MEM_ACCESS_CTRL_ADDR_CHECK_EN):
//   defined   -> requests with req_addr >= DEPTH skip the memory entirely and
//                complete one cycle later with resp_err=1 and resp_rdata=0.
//   undefined -> no comparator, resp_err tied low, all addresses issued as-is.
//
// Ports:
//   clk, clear                        clock, synchronous active-high reset
//   req, req_we, req_addr, req_wdata  request from the control unit
//   req_ready                         high only while idle
//   resp_valid, resp_rdata, resp_err  one-cycle completion and load result
//   mem_address, mem_read, mem_write, mem_datain, mem_q   memory interface

module mem_access_ctrl #(
  parameter int DEPTH  = 512,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        req,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_datain,
  input  logic [31:0] mem_q
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  // WAIT is left on the edge where the counter is already zero, so the
  // counter starts at RD_LAT-1 to give exactly RD_LAT WAIT cycles.
  localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

  state_t      state_q, state_d;
  logic [31:0] mar_q, mar_d;
  logic [31:0] mdr_q, mdr_d;
  logic        we_q, we_d;
  logic [1:0]  cnt_q, cnt_d;

`ifdef MEM_ACCESS_CTRL_ADDR_CHECK_EN
  logic err_q, err_d;
  logic addr_oor;

  assign addr_oor = (req_addr >= 32'(DEPTH));
  assign resp_err = (state_q == DONE) && err_q;
`else
  // DEPTH only matters when range checking is built in.
  logic unused_depth;

  assign unused_depth = (DEPTH > 0);
  assign resp_err     = 1'b0;
`endif

  // Next-state and register updates
  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
`ifdef MEM_ACCESS_CTRL_ADDR_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          mar_d   = req_addr;
          we_d    = req_we;
          state_d = ACCESS;
          if (req_we) begin
            mdr_d = req_wdata;
          end
`ifdef MEM_ACCESS_CTRL_ADDR_CHECK_EN
          err_d = 1'b0;
          // Out-of-range requests never touch the memory.
          if (addr_oor) begin
            mdr_d   = '0;
            err_d   = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = DONE;
        end else begin
          cnt_d   = LAT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end else begin
          mdr_d   = mem_q;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded purely from registered state
  always_comb begin
    req_ready   = (state_q == IDLE);
    resp_valid  = (state_q == DONE);
    mem_write   = (state_q == ACCESS) && we_q;
    mem_read    = ((state_q == ACCESS) && !we_q) || (state_q == WAIT);
    mem_address = mar_q;
    mem_datain  = mdr_q;
    resp_rdata  = mdr_q;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      we_q    <= 1'b0;
      cnt_q   <= 2'd0;
`ifdef MEM_ACCESS_CTRL_ADDR_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
`ifdef MEM_ACCESS_CTRL_ADDR_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule
